// File: rtl/ssc_pkg.sv
// Shared types and constants for the spread-spectrum profile generator.
package ssc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ssc_state_e;

  typedef enum logic [1:0] {
    CAL_IDLE  = 2'd0,
    CAL_ARM   = 2'd1,
    CAL_COUNT = 2'd2
  } ssc_cal_e;

  localparam logic SSC_DOWN   = 1'b0;
  localparam logic SSC_CENTER = 1'b1;

endpackage

// File: rtl/ssc_period_meter.sv
// Measures one modulation period in clk_in cycles, boundary to boundary.
// A request outside RUN, or leaving RUN mid-measurement, reports an error.
module ssc_period_meter
  import ssc_pkg::*;
#(
  parameter int CAL_W = 24
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             boundary,
  input  logic             cal_req,
  output logic             cal_done,
  output logic             cal_err,
  output logic [CAL_W-1:0] cal_period
);

  ssc_cal_e         cal_state_q, cal_state_d;
  logic [CAL_W-1:0] count_q, count_d;
  logic [CAL_W-1:0] period_q, period_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Calibration state, running count and registered result
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cal_state_q <= CAL_IDLE;
      count_q     <= '0;
      period_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cal_state_q <= cal_state_d;
      count_q     <= count_d;
      period_q    <= period_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Arm on request, start counting at the first boundary, report at the next
  always_comb begin
    cal_state_d = cal_state_q;
    count_d     = count_q;
    period_d    = period_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (cal_state_q)
      CAL_IDLE: begin
        if (cal_req) begin
          if (run) begin
            cal_state_d = CAL_ARM;
          end else begin
            done_d   = 1'b1;
            err_d    = 1'b1;
            period_d = '0;
          end
        end
      end
      CAL_ARM: begin
        if (!run) begin
          cal_state_d = CAL_IDLE;
          done_d      = 1'b1;
          err_d       = 1'b1;
          period_d    = '0;
        end else if (boundary) begin
          cal_state_d = CAL_COUNT;
          count_d     = CAL_W'(1);
        end
      end
      CAL_COUNT: begin
        if (!run) begin
          cal_state_d = CAL_IDLE;
          done_d      = 1'b1;
          err_d       = 1'b1;
          period_d    = '0;
        end else if (boundary) begin
          cal_state_d = CAL_IDLE;
          done_d      = 1'b1;
          period_d    = count_q;
        end else if (count_q != '1) begin
          count_d = count_q + CAL_W'(1);
        end
      end
      default: cal_state_d = CAL_IDLE;
    endcase
  end

  assign cal_done   = done_q;
  assign cal_err    = err_q;
  assign cal_period = period_q;

endmodule

// File: rtl/ssc_profile_gen.sv
// Spread-spectrum profile generator: triangle offset word with down/center
// spread, drain-to-zero stop, boundary-shadowed depth/step and calibration.
module ssc_profile_gen
  import ssc_pkg::*;
#(
  parameter int OFS_W = 12,
  parameter int CNT_W = 16,
  parameter int CAL_W = 24
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             cfg_center,
  input  logic [OFS_W-1:0] cfg_depth,
  input  logic [OFS_W-1:0] cfg_step,
  input  logic             cfg_load,
  output logic             cfg_ack,
  output logic [OFS_W:0]   ofs_out,
  output logic [1:0]       stat_state,
  output logic [CNT_W-1:0] period_cnt,
  input  logic             cal_req,
  output logic             cal_done,
  output logic             cal_err,
  output logic [CAL_W-1:0] cal_period
);

  ssc_state_e       state_q, state_d;
  logic [OFS_W-1:0] tri_q, tri_d;
  logic             dir_q, dir_d;
  logic [OFS_W-1:0] sh_depth_q, sh_depth_d;
  logic [OFS_W-1:0] sh_step_q, sh_step_d;
  logic             sh_center_q, sh_center_d;
  logic             load_pend_q, load_pend_d;
  logic             ack_q, ack_d;
  logic [OFS_W:0]   ofs_q, ofs_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  logic [OFS_W-1:0] half;
  logic             degen;
  logic [OFS_W:0]   up_sum;
  logic [OFS_W-1:0] step_tri;
  logic             step_dir;
  logic             step_bnd;
  logic             crossed;
  logic             load_eff;
  logic             stop;
  logic             boundary;
  logic             run_now;

  // State, triangle, shadows and registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tri_q       <= '0;
      dir_q       <= 1'b1;
      sh_depth_q  <= '0;
      sh_step_q   <= '0;
      sh_center_q <= 1'b0;
      load_pend_q <= 1'b0;
      ack_q       <= 1'b0;
      ofs_q       <= '0;
      pcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      tri_q       <= tri_d;
      dir_q       <= dir_d;
      sh_depth_q  <= sh_depth_d;
      sh_step_q   <= sh_step_d;
      sh_center_q <= sh_center_d;
      load_pend_q <= load_pend_d;
      ack_q       <= ack_d;
      ofs_q       <= ofs_d;
      pcnt_q      <= pcnt_d;
    end
  end

  // One triangle step from the current shadows; the extra sum bit prevents wrap
  always_comb begin
    half     = sh_depth_q >> 1;
    degen    = (sh_depth_q == '0) || (sh_step_q == '0);
    up_sum   = {1'b0, tri_q} + {1'b0, sh_step_q};
    step_tri = tri_q;
    step_dir = dir_q;
    step_bnd = 1'b0;
    if (!degen) begin
      if (dir_q) begin
        if (up_sum >= {1'b0, sh_depth_q}) begin
          step_tri = sh_depth_q;
          step_dir = 1'b0;
        end else begin
          step_tri = up_sum[OFS_W-1:0];
        end
      end else if (tri_q <= sh_step_q) begin
        step_tri = '0;
        step_dir = 1'b1;
        step_bnd = 1'b1;
      end else begin
        step_tri = tri_q - sh_step_q;
      end
    end
    crossed = ((tri_q <= half) && (step_tri >= half)) ||
              ((tri_q >= half) && (step_tri <= half));
  end

  // Main FSM: start, run, drain to the zero point; boundary-time shadow loads
  always_comb begin
    state_d     = state_q;
    tri_d       = tri_q;
    dir_d       = dir_q;
    sh_depth_d  = sh_depth_q;
    sh_step_d   = sh_step_q;
    sh_center_d = sh_center_q;
    load_pend_d = load_pend_q;
    ack_d       = 1'b0;
    pcnt_d      = pcnt_q;
    boundary    = 1'b0;
    load_eff    = 1'b0;
    stop        = 1'b0;
    case (state_q)
      IDLE: begin
        load_pend_d = 1'b0;
        if (cfg_en) begin
          state_d     = RUN;
          sh_depth_d  = cfg_depth;
          sh_step_d   = cfg_step;
          sh_center_d = cfg_center;
          pcnt_d      = '0;
          if (cfg_center == SSC_CENTER) begin
            tri_d = cfg_depth >> 1;
            dir_d = 1'b0;
          end else begin
            tri_d = '0;
            dir_d = 1'b1;
          end
        end
      end
      RUN, DRAIN: begin
        tri_d       = step_tri;
        dir_d       = step_dir;
        boundary    = step_bnd;
        load_eff    = load_pend_q | cfg_load;
        load_pend_d = load_eff;
        // A frozen profile has no boundaries, so loads take effect at once
        if (load_eff && (step_bnd || degen)) begin
          sh_depth_d  = cfg_depth;
          sh_step_d   = cfg_step;
          ack_d       = 1'b1;
          load_pend_d = 1'b0;
        end
        if (step_bnd && (pcnt_q != '1)) begin
          pcnt_d = pcnt_q + CNT_W'(1);
        end
        if (cfg_en) begin
          state_d = RUN;
        end else begin
          stop = degen || ((sh_center_q == SSC_CENTER) ? crossed : step_bnd);
          if (stop) begin
            state_d = IDLE;
            if (sh_center_q == SSC_CENTER) begin
              tri_d = sh_depth_d >> 1;
              dir_d = 1'b0;
            end else begin
              tri_d = '0;
              dir_d = 1'b1;
            end
          end else begin
            state_d = DRAIN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tri_d   = '0;
        dir_d   = 1'b1;
      end
    endcase

    // Output mapping uses the shadows in force after this edge
    if (state_d == IDLE) begin
      ofs_d = '0;
    end else if (sh_center_d == SSC_DOWN) begin
      ofs_d = '0 - {1'b0, tri_d};
    end else begin
      ofs_d = {1'b0, tri_d} - {1'b0, sh_depth_d >> 1};
    end
  end

  assign run_now = (state_q == RUN);

  ssc_period_meter #(
    .CAL_W (CAL_W)
  ) u_meter (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .run        (run_now),
    .boundary   (boundary),
    .cal_req    (cal_req),
    .cal_done   (cal_done),
    .cal_err    (cal_err),
    .cal_period (cal_period)
  );

  assign cfg_ack    = ack_q;
  assign ofs_out    = ofs_q;
  assign stat_state = state_q;
  assign period_cnt = pcnt_q;

endmodule

// File: tb/tb_ssc_profile_gen.sv
// Scoreboard bench for ssc_profile_gen: a ramp-list reference model predicts
// each cycle's outputs and calibration results; a monitor compares them.
module tb_ssc_profile_gen;

  localparam int OFS_W = 12;
  localparam int CNT_W = 16;
  localparam int CAL_W = 24;

  logic             clk_in = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_en = 1'b0;
  logic             cfg_center = 1'b0;
  logic [OFS_W-1:0] cfg_depth = '0;
  logic [OFS_W-1:0] cfg_step = '0;
  logic             cfg_load = 1'b0;
  logic             cal_req = 1'b0;
  logic             cfg_ack;
  logic [OFS_W:0]   ofs_out;
  logic [1:0]       stat_state;
  logic [CNT_W-1:0] period_cnt;
  logic             cal_done;
  logic             cal_err;
  logic [CAL_W-1:0] cal_period;

  ssc_profile_gen #(.OFS_W(OFS_W), .CNT_W(CNT_W), .CAL_W(CAL_W)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .cfg_center (cfg_center),
    .cfg_depth  (cfg_depth),
    .cfg_step   (cfg_step),
    .cfg_load   (cfg_load),
    .cfg_ack    (cfg_ack),
    .ofs_out    (ofs_out),
    .stat_state (stat_state),
    .period_cnt (period_cnt),
    .cal_req    (cal_req),
    .cal_done   (cal_done),
    .cal_err    (cal_err),
    .cal_period (cal_period)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int ofs;
    int st;
    int pcnt;
    int ack;
    int done;
  } exp_t;

  typedef struct {
    int err;
    int period;
  } cal_t;

  exp_t exp_q[$];
  cal_t cal_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: the profile is a list of upcoming tri values per period
  int m_state, m_tri, m_depth, m_step, m_center, m_pend, m_pcnt;
  int m_cal, m_cal_start, m_calp, m_cyc;
  int seg[$];

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // Full period from zero: ramp up clamped at depth, then down clamped at zero
  function void build_period(int d, int s);
    int t;
    seg.delete();
    t = 0;
    do begin
      t = (t + s >= d) ? d : t + s;
      seg.push_back(t);
    end while (t < d);
    do begin
      t = (t <= s) ? 0 : t - s;
      seg.push_back(t);
    end while (t > 0);
  endfunction

  // Descent from a mid point to zero (center-spread opening half period)
  function void build_desc(int t0, int s);
    int t;
    seg.delete();
    t = t0;
    do begin
      t = (t <= s) ? 0 : t - s;
      seg.push_back(t);
    end while (t > 0);
  endfunction

  function void model_reset();
    m_state = 0; m_tri = 0; m_depth = 0; m_step = 0; m_center = 0;
    m_pend = 0; m_pcnt = 0; m_cal = 0; m_cal_start = 0; m_calp = 0; m_cyc = 0;
    seg.delete();
    cal_q.delete();
  endfunction

  function void model_step(output exp_t e);
    int   pre, hq, prev;
    bit   degen, bnd, pend_eff, stop;
    cal_t c;
    m_cyc++;
    pre = m_state;
    bnd = 0;
    e.ack = 0;
    e.done = 0;
    if (m_state == 0) begin
      m_pend = 0;
      if (cfg_en) begin
        m_depth = int'(cfg_depth); m_step = int'(cfg_step); m_center = int'(cfg_center);
        m_pcnt = 0; m_state = 1;
        m_tri = m_center ? m_depth / 2 : 0;
        if (m_depth == 0 || m_step == 0) seg.delete();
        else if (m_center != 0) build_desc(m_tri, m_step);
        else build_period(m_depth, m_step);
      end
    end else begin
      degen = (m_depth == 0) || (m_step == 0);
      hq = m_depth / 2;
      prev = m_tri;
      pend_eff = (m_pend != 0) || cfg_load;
      if (!degen) begin
        m_tri = seg.pop_front();
        bnd = (seg.size() == 0);
      end
      m_pend = pend_eff;
      if ((bnd || degen) && pend_eff) begin
        m_depth = int'(cfg_depth); m_step = int'(cfg_step);
        e.ack = 1; m_pend = 0;
      end
      if (bnd && m_pcnt < 65535) m_pcnt++;
      if (bnd || (degen && e.ack != 0)) begin
        if (m_depth == 0 || m_step == 0) seg.delete();
        else if (m_tri == 0) build_period(m_depth, m_step);
        else build_desc(m_tri, m_step);
      end
      if (cfg_en) begin
        m_state = 1;
      end else begin
        if (m_center != 0)
          stop = degen || (prev <= hq && m_tri >= hq) || (prev >= hq && m_tri <= hq);
        else
          stop = degen || bnd;
        if (stop) begin
          m_state = 0;
          m_tri = m_center ? m_depth / 2 : 0;
          seg.delete();
        end else begin
          m_state = 2;
        end
      end
    end
    // Calibration: judged against the state held during the cycle
    case (m_cal)
      0: if (cal_req) begin
        if (pre == 1) m_cal = 1;
        else begin e.done = 1; c.err = 1; m_calp = 0; end
      end
      1: if (pre != 1) begin
        m_cal = 0; e.done = 1; c.err = 1; m_calp = 0;
      end else if (bnd) begin
        m_cal = 2; m_cal_start = m_cyc;
      end
      default: if (pre != 1) begin
        m_cal = 0; e.done = 1; c.err = 1; m_calp = 0;
      end else if (bnd) begin
        m_cal = 0; e.done = 1; c.err = 0; m_calp = m_cyc - m_cal_start;
      end
    endcase
    if (e.done != 0) begin
      c.period = m_calp;
      cal_q.push_back(c);
    end
    e.ofs  = (m_state == 0) ? 0 : (m_center != 0) ? m_tri - m_depth / 2 : -m_tri;
    e.st   = m_state;
    e.pcnt = m_pcnt;
  endfunction

  // Monitor: one expectation per clock, calibration results popped on cal_done
  exp_t mon_e;
  cal_t mon_c;
  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ofs_out", int'($signed(ofs_out)), mon_e.ofs);
      check("stat_state", int'(stat_state), mon_e.st);
      check("period_cnt", int'(period_cnt), mon_e.pcnt);
      check("cfg_ack", int'(cfg_ack), mon_e.ack);
      check("cal_done", int'(cal_done), mon_e.done);
      if (cfg_ack) $display("ack period_cnt=%0d t=%0t", period_cnt, $time);
      if (cal_done) begin
        $display("cal done err=%0d period=%0d t=%0t", cal_err, cal_period, $time);
        if (cal_q.size() == 0) begin
          check("cal_unexpected", 1, 0);
        end else begin
          mon_c = cal_q.pop_front();
          check("cal_err", int'(cal_err), mon_c.err);
          check("cal_period", int'(cal_period), mon_c.period);
        end
      end
    end
  end

  task automatic tick();
    exp_t e;
    model_step(e);
    @(posedge clk_in);
    #1;
    exp_q.push_back(e);
    cfg_load = 1'b0;
    cal_req  = 1'b0;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    int k;
    cfg_en = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (m_state != 0 && k < 700);
    tick();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ofs"}, int'($signed(ofs_out)), 0);
    check({tag, "_state"}, int'(stat_state), 0);
    check({tag, "_pcnt"}, int'(period_cnt), 0);
    check({tag, "_ack"}, int'(cfg_ack), 0);
    check({tag, "_done"}, int'(cal_done), 0);
    check({tag, "_err"}, int'(cal_err), 0);
    check({tag, "_period"}, int'(cal_period), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_n = 1'b1;

    // Down-spread 100/10 with a calibration request
    cfg_center = 1'b0; cfg_depth = 12'd100; cfg_step = 12'd10; cfg_en = 1'b1;
    ticks(2);
    cal_req = 1'b1;
    ticks(58);
    drain();

    // Calibration refused outside RUN
    cal_req = 1'b1;
    ticks(3);

    // Center-spread 100/30, then drain to zero
    cfg_center = 1'b1; cfg_step = 12'd30; cfg_en = 1'b1;
    ticks(40);
    drain();
    ticks(2);

    // Mid-ramp load of depth 40 takes effect at the next boundary
    cfg_center = 1'b0; cfg_depth = 12'd100; cfg_step = 12'd10; cfg_en = 1'b1;
    ticks(5);
    cfg_depth = 12'd40; cfg_load = 1'b1;
    ticks(61);
    drain();

    // Calibration aborted by disable while counting
    cfg_depth = 12'd100; cfg_en = 1'b1;
    ticks(2);
    cal_req = 1'b1;
    ticks(26);
    drain();

    // Frozen profile (step 0): output held, calibration waits then aborts
    cfg_step = 12'd0; cfg_en = 1'b1;
    ticks(5);
    cal_req = 1'b1;
    ticks(21);
    drain();
    ticks(2);

    // Step larger than depth, then all-ones in both modes
    cfg_depth = 12'd5; cfg_step = 12'd7; cfg_en = 1'b1;
    ticks(10);
    drain();
    cfg_depth = '1; cfg_step = '1; cfg_en = 1'b1;
    ticks(10);
    drain();
    cfg_center = 1'b1; cfg_en = 1'b1;
    ticks(10);
    drain();

    // Asynchronous reset in the middle of RUN
    cfg_center = 1'b0; cfg_depth = 12'd100; cfg_step = 12'd10; cfg_en = 1'b1;
    ticks(15);
    @(negedge clk_in);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    cfg_en = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Randomised episodes: loads, calibration requests, enable toggling
    for (int ep = 0; ep < 25; ep++) begin
      int n;
      cfg_center = 1'($urandom_range(0, 1));
      cfg_depth  = 12'(cfg_center ? $urandom_range(2, 250) : $urandom_range(0, 250));
      cfg_step   = 12'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60));
      cfg_en     = 1'b1;
      n = $urandom_range(10, 80);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 15) == 0) begin
          cfg_load  = 1'b1;
          cfg_depth = 12'($urandom_range(2, 250));
          cfg_step  = 12'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60));
        end
        if ($urandom_range(0, 20) == 0) cal_req = 1'b1;
        if ($urandom_range(0, 30) == 0) cfg_en = ~cfg_en;
        tick();
      end
      drain();
    end

    repeat (3) @(negedge clk_in);
    #1;
    check("exp_queue_left", exp_q.size(), 0);
    check("cal_queue_left", cal_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssc_profile_gen.md
# ssc_profile_gen

Second-generation spread-spectrum profile generator: produces a registered, signed frequency-offset word per clock for a fractional-N divider or phase interpolator downstream of the PLL, instead of perturbing a clock directly. It adds:
- parametrised widths
- down-spread and center-spread modes
- glitch-free start/stop (drain to the profile's zero point)
- shadowed depth/step updates at period boundaries
- a real period-measurement calibration

## Interface
- OFS_W, 12: magnitude width of depth/step; output is OFS_W+1 bits signed
- CNT_W, 16: width of the saturating period counter
- CAL_W, 24: width of the calibration period measurement
- clk_in  in  1  reference clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_en  in  1  level; enable modulation
- cfg_center  in  1  0 = down-spread, 1 = center-spread; sampled only on IDLE->RUN
- cfg_depth  in  OFS_W  peak-to-peak deviation, unsigned
- cfg_step  in  OFS_W  triangle increment per cycle, unsigned
- cfg_load  in  1  pulse; request depth/step shadow update
- cfg_ack  out  1  pulse; shadow update applied this cycle
- ofs_out  out  OFS_W+1  signed offset word, two's complement
- stat_state  out  2  0 IDLE, 1 RUN, 2 DRAIN
- period_cnt  out  CNT_W  completed modulation periods, saturating
- cal_req  in  1  pulse; measure one modulation period
- cal_done  out  1  pulse; measurement result valid
- cal_err  out  1  valid with cal_done; 1 = measurement aborted/refused
- cal_period  out  CAL_W  clk_in cycles in one period, saturating

## Operation
- Internal state:
  - tri: unsigned OFS_W bits
  - dir: 1 = up
  - shadow: sh_depth, sh_step, sh_center
  - half = sh_depth>>1
- Output mapping:
  - down-spread: ofs_out = -tri
  - center-spread: ofs_out = tri - half
- RUN triangle: arithmetic in OFS_W+1 bits, no wrap.
  - Up: if tri+step >= depth, then tri=depth and dir=0; else tri += step.
  - Down: if tri <= step, then tri=0, dir=1 and a **boundary** occurs; else tri -= step.
- Boundary actions:
  - period_cnt increments (saturating at all-ones).
  - A pending cfg_load copies cfg_depth/cfg_step into the shadows and pulses cfg_ack.
  - A load pending is latched until consumed; repeated cfg_load pulses merge into one.
- Center-mode load at boundary gives an accepted output step of (old_half - new_half).
- Degenerate case, sh_depth==0 or sh_step==0:
  - tri is frozen at the start point, and there are no boundaries.
  - cfg_load applies the cycle after it is seen.
- IDLE->RUN on cfg_en=1:
  - Latch all shadows from cfg_*, clear period_cnt and any pending load.
  - Start point: down-spread tri=0, dir=1; center tri=half, dir=0.
  - Either way, ofs_out starts at 0.
- RUN->DRAIN on cfg_en=0. The profile continues until the stop point, then tri goes to the start point and state goes to IDLE.
  - Down-spread stop point: boundary.
  - Center stop point: first cycle tri reaches or crosses half in either direction.
- DRAIN->RUN when cfg_en=1 again before the stop point; no discontinuity.
- Calibration FSM (CAL_IDLE, CAL_ARM, CAL_COUNT):
  - cal_req outside RUN gives cal_done=1, cal_err=1, cal_period=0 next cycle.
  - cal_req in RUN goes to ARM.
  - At the next boundary, go to COUNT with count=1. Count increments each cycle.
  - At the following boundary, cal_period=count, cal_done=1, cal_err=0.
  - Leaving RUN during ARM/COUNT gives cal_done=1, cal_err=1.
  - cal_req while busy is ignored.
  - Degenerate profile in ARM waits indefinitely, until cal_err on RUN exit.

## Timing
- Reset values:
  - all outputs 0; stat_state=IDLE
  - tri=0, dir=1, shadows 0, cal FSM CAL_IDLE
- Reset mid-operation clears everything immediately; no drain.
- All outputs are registered.
- cfg_en sampled high at edge N gives stat_state=RUN and ofs_out=0 after edge N; the first stepped value follows edge N+1.
- cfg_ack, period_cnt, shadow update: same edge as the boundary tri=0 update.
- Down-spread period = 2*ceil(depth/step) cycles.
- cal_done: same edge as the terminating boundary.
- Simultaneous cfg_en=0 and boundary in down-spread: direct RUN->IDLE. A pending load is applied anyway.

## Structure
- Shared package ssc_pkg holds:
  - enum ssc_state_e {IDLE, RUN, DRAIN}
  - enum ssc_cal_e
  - mode constants SSC_DOWN=0, SSC_CENTER=1
- Sub-module ssc_period_meter contains the calibration FSM and saturating counter.
  - Inputs: run, boundary, cal_req.
  - Outputs: cal_done, cal_err, cal_period.
- Top holds the main FSM, the triangle datapath and the shadow registers.

## Test plan
- Down-spread, depth=100, step=10, enable: ofs_out runs 0,-10..-100,-90..0. Boundary every 20 cycles; period_cnt=3 after 60 cycles.
- Center-spread, depth=100, step=30: ofs_out starts 0, clamps at -50 and +50. Drop cfg_en: drain ends exactly at ofs_out=0, then IDLE.
- cfg_load depth=40 mid-ramp, down-spread: no change until the next boundary. cfg_ack pulses once there; subsequent peak is -40.
- Calibration:
  - depth=100, step=10 in RUN: cal_period=20, cal_err=0.
  - cal_req in IDLE: cal_err=1 next cycle.
- Edge cases:
  - cfg_en drops during cal COUNT: cal_err=1.
  - step=0: ofs_out held at 0, no boundaries.
  - Assert rst_n low mid-RUN: all outputs 0 asynchronously.
- step > depth (depth=5, step=7): tri alternates 0/5, boundary every 2 cycles. Verify no overflow with depth=step=all-ones.
